// File: rtl/and_gate_unit.sv
// and_gate_unit
// Registered, flow-controlled bitwise AND of two operands with a two-entry
// skid buffer (output register plus one skid entry). Each operand pair
// accepted on the input handshake yields exactly one result, delivered in
// order on the output handshake, together with zero/all-ones status flags
// and a running count of delivered results.
//
// Ports:
//   Clock        rising-edge clock
//   Reset        synchronous, active-high reset
//   In_Valid     operand pair on Input_A/Input_B is valid
//   In_Ready     block can accept a pair this cycle (registered: skid empty)
//   Input_A/B    operands, WIDTH bits
//   Out_Valid    Output and flags carry a valid result
//   Out_Ready    downstream takes the result this cycle
//   Output       Input_A & Input_B of the accepted pair
//   Out_Zero     Output == 0, qualified by Out_Valid
//   Out_AllOnes  Output is all ones, qualified by Out_Valid
//   Op_Count     results transferred since reset (wraps)
module and_gate_unit #(
    parameter int WIDTH       = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   In_Valid,
    output logic                   In_Ready,
    input  logic [WIDTH-1:0]       Input_A,
    input  logic [WIDTH-1:0]       Input_B,
    output logic                   Out_Valid,
    input  logic                   Out_Ready,
    output logic [WIDTH-1:0]       Output,
    output logic                   Out_Zero,
    output logic                   Out_AllOnes,
    output logic [COUNT_WIDTH-1:0] Op_Count
);

    function automatic logic is_zero(input logic [WIDTH-1:0] value);
        return (value == {WIDTH{1'b0}});
    endfunction

    function automatic logic is_all_ones(input logic [WIDTH-1:0] value);
        return (&value);
    endfunction

    logic                   out_valid_r, out_valid_s;
    logic [WIDTH-1:0]       out_data_r,  out_data_s;
    logic                   out_zero_r,  out_zero_s;
    logic                   out_ones_r,  out_ones_s;
    logic                   skid_valid_r, skid_valid_s;
    logic [WIDTH-1:0]       skid_data_r,  skid_data_s;
    logic                   ready_r,     ready_s;
    logic [COUNT_WIDTH-1:0] count_r,     count_s;
    logic                   accept_s;
    logic                   xfer_s;
    logic [WIDTH-1:0]       and_s;

    // Next-state logic for the output register, skid entry, ready flag and counter
    always_comb begin
        accept_s     = In_Valid & ready_r;
        xfer_s       = out_valid_r & Out_Ready;
        and_s        = Input_A & Input_B;
        out_valid_s  = out_valid_r;
        out_data_s   = out_data_r;
        out_zero_s   = out_zero_r;
        out_ones_s   = out_ones_r;
        skid_valid_s = skid_valid_r;
        skid_data_s  = skid_data_r;
        count_s      = count_r;

        if (xfer_s) begin
            count_s = count_r + {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_s = count_r;
        end

        if (!out_valid_r || xfer_s) begin
            // Output slot is free this edge: the oldest pending result fills it.
            if (skid_valid_r) begin
                out_valid_s  = 1'b1;
                out_data_s   = skid_data_r;
                out_zero_s   = is_zero(skid_data_r);
                out_ones_s   = is_all_ones(skid_data_r);
                skid_valid_s = 1'b0;
            end else if (accept_s) begin
                out_valid_s = 1'b1;
                out_data_s  = and_s;
                out_zero_s  = is_zero(and_s);
                out_ones_s  = is_all_ones(and_s);
            end else begin
                // Going empty: keep the last data, but flags must read 0.
                out_valid_s = 1'b0;
                out_zero_s  = 1'b0;
                out_ones_s  = 1'b0;
            end
        end else begin
            // Output stalled: a newly accepted pair parks in the skid entry.
            if (accept_s) begin
                skid_valid_s = 1'b1;
                skid_data_s  = and_s;
            end else begin
                skid_valid_s = skid_valid_r;
                skid_data_s  = skid_data_r;
            end
        end

        ready_s = ~skid_valid_s;
    end

    // State registers with synchronous reset; In_Ready stays low while Reset is high
    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_valid_r  <= 1'b0;
            out_data_r   <= {WIDTH{1'b0}};
            out_zero_r   <= 1'b0;
            out_ones_r   <= 1'b0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= {WIDTH{1'b0}};
            ready_r      <= 1'b0;
            count_r      <= {COUNT_WIDTH{1'b0}};
        end else begin
            out_valid_r  <= out_valid_s;
            out_data_r   <= out_data_s;
            out_zero_r   <= out_zero_s;
            out_ones_r   <= out_ones_s;
            skid_valid_r <= skid_valid_s;
            skid_data_r  <= skid_data_s;
            ready_r      <= ready_s;
            count_r      <= count_s;
        end
    end

    assign In_Ready    = ready_r;
    assign Out_Valid   = out_valid_r;
    assign Output      = out_data_r;
    assign Out_Zero    = out_zero_r;
    assign Out_AllOnes = out_ones_r;
    assign Op_Count    = count_r;

endmodule

// File: tb/tb_and_gate_unit.sv
// Testbench for and_gate_unit: a WIDTH=1 instance for the truth table and a
// WIDTH=8 / COUNT_WIDTH=3 instance driven through directed and random
// traffic, compared cycle by cycle against a queue-based reference model.
module tb_and_gate_unit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;

    // WIDTH=1 instance signals
    logic       v1 = 1'b0, rdy1, ov1, zero1, ones1;
    logic [0:0] a1 = 1'b0, b1 = 1'b0, out1;
    logic       ordy1 = 1'b1;
    logic [15:0] cnt1;

    // WIDTH=8 instance signals
    logic       v8 = 1'b0, rdy8, ov8, zero8, ones8;
    logic [7:0] a8 = 8'h00, b8 = 8'h00, out8;
    logic       ordy8 = 1'b0;
    logic [2:0] cnt8;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: queue of pending results, last delivered, count, ready
    logic [7:0] m_q[$];
    logic [7:0] m_last;
    int         m_count;
    bit         m_rdy;

    always #5 clock = ~clock;

    and_gate_unit #(.WIDTH(1), .COUNT_WIDTH(16)) u_w1 (
        .Clock(clock), .Reset(reset), .In_Valid(v1), .In_Ready(rdy1),
        .Input_A(a1), .Input_B(b1), .Out_Valid(ov1), .Out_Ready(ordy1),
        .Output(out1), .Out_Zero(zero1), .Out_AllOnes(ones1), .Op_Count(cnt1)
    );

    and_gate_unit #(.WIDTH(8), .COUNT_WIDTH(3)) u_w8 (
        .Clock(clock), .Reset(reset), .In_Valid(v8), .In_Ready(rdy8),
        .Input_A(a8), .Input_B(b8), .Out_Valid(ov8), .Out_Ready(ordy8),
        .Output(out8), .Out_Zero(zero8), .Out_AllOnes(ones8), .Op_Count(cnt8)
    );

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Compare the WIDTH=8 instance against the model (called at negedge)
    task automatic check_w8();
        logic [7:0] exp_out;
        bit         has;
        has     = (m_q.size() > 0);
        exp_out = has ? m_q[0] : m_last;
        check_value("w8_out_valid", 32'(ov8), 32'(has));
        check_value("w8_in_ready", 32'(rdy8), 32'(m_rdy));
        check_value("w8_op_count", 32'(cnt8), 32'(m_count % 8));
        check_value("w8_output", 32'(out8), 32'(exp_out));
        check_value("w8_zero", 32'(zero8), 32'(has && exp_out == 8'h00));
        check_value("w8_allones", 32'(ones8), 32'(has && exp_out == 8'hFF));
    endtask

    // One cycle on the WIDTH=8 instance: check, drive, clock edge, advance model
    task automatic step8(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy, input logic rst);
        bit acc, xf;
        check_w8();
        v8 = v; a8 = a; b8 = b; ordy8 = ordy; reset = rst;
        @(posedge clock);
        if (rst) begin
            m_q.delete();
            m_last  = 8'h00;
            m_count = 0;
            m_rdy   = 1'b0;
        end else begin
            acc = v && m_rdy;
            xf  = (m_q.size() > 0) && ordy;
            if (xf) begin
                m_last = m_q.pop_front();
                m_count++;
            end
            if (acc) m_q.push_back(a & b);
            m_rdy = (m_q.size() < 2);
        end
        @(negedge clock);
    endtask

    initial begin
        // ---------------- WIDTH=1 truth table ----------------
        reset = 1'b1;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check_value("w1_reset_in_ready", 32'(rdy1), 32'd0);
        check_value("w1_reset_valid", 32'(ov1), 32'd0);
        check_value("w1_reset_count", 32'(cnt1), 32'd0);
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_value("w1_in_ready_after_reset", 32'(rdy1), 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic ea, eb;
            ea = i[0];
            eb = i[1];
            v1 = 1'b1; a1 = ea; b1 = eb;
            @(posedge clock);
            @(negedge clock);
            check_value("w1_valid", 32'(ov1), 32'd1);
            check_value("w1_output", 32'(out1), 32'(ea & eb));
            check_value("w1_zero", 32'(zero1), 32'(!(ea & eb)));
            check_value("w1_allones", 32'(ones1), 32'(ea & eb));
        end
        v1 = 1'b0;
        @(posedge clock);
        @(negedge clock);
        check_value("w1_final_count", 32'(cnt1), 32'd4);
        check_value("w1_empty", 32'(ov1), 32'd0);
        check_value("w1_empty_allones", 32'(ones1), 32'd0);

        // ---------------- WIDTH=8 instance ----------------
        reset = 1'b1;
        v8 = 1'b0; ordy8 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        m_q.delete(); m_last = 8'h00; m_count = 0; m_rdy = 1'b0;
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Vectors
        step8(1'b1, 8'hF0, 8'h3C, 1'b1, 1'b0);
        step8(1'b1, 8'hFF, 8'hFF, 1'b1, 1'b0);
        step8(1'b1, 8'hAA, 8'h55, 1'b1, 1'b0);
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Backpressure: three back-to-back pairs with the output stalled
        step8(1'b1, 8'h81, 8'hC3, 1'b0, 1'b0);
        step8(1'b1, 8'h7E, 8'h3F, 1'b0, 1'b0);
        step8(1'b1, 8'h0F, 8'hFF, 1'b0, 1'b0);
        step8(1'b1, 8'h0F, 8'hFF, 1'b0, 1'b0);
        check_value("bp_in_ready_low", 32'(rdy8), 32'd0);
        check_value("bp_output_stable", 32'(out8), 32'(8'h81 & 8'hC3));
        for (int i = 0; i < 3; i++) step8(1'b1, 8'h0F, 8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Streaming: 16 consecutive random pairs, Out_Ready held high
        for (int i = 0; i < 16; i++) begin
            step8(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
            check_value("stream_in_ready", 32'(rdy8), 32'd1);
        end
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Reset with both entries full
        step8(1'b1, 8'hFF, 8'hF7, 1'b0, 1'b0);
        step8(1'b1, 8'hEE, 8'hFF, 1'b0, 1'b0);
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
        check_value("mid_reset_valid", 32'(ov8), 32'd0);
        check_value("mid_reset_output", 32'(out8), 32'd0);
        check_value("mid_reset_count", 32'(cnt8), 32'd0);
        check_value("mid_reset_in_ready", 32'(rdy8), 32'd0);
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_value("post_reset_in_ready", 32'(rdy8), 32'd1);
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        // Counter wrap: 9 deliveries, 3-bit count ends at 1
        for (int i = 0; i < 9; i++) step8(1'b1, 8'($urandom), 8'($urandom), 1'b1, 1'b0);
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        check_value("wrap_count", 32'(cnt8), 32'd1);

        // Random traffic with random backpressure and occasional reset
        for (int i = 0; i < 400; i++) begin
            step8(1'($urandom), 8'($urandom), 8'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 63) == 0));
        end
        step8(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/and_gate_unit.md
Name: and_gate_unit

Overview:
- Registered, flow-controlled bitwise AND of two operands.
- Each operand pair accepted on the input handshake produces exactly one result on the output handshake.
- Results are presented with zero/all-ones status flags and a running count of results delivered.
- Sits as a leaf logic stage in a valid/ready datapath. A two-entry skid buffer allows full throughput while keeping In_Ready registered.

Parameters:
- WIDTH, 1, operand and result width in bits (>=1).
- COUNT_WIDTH, 16, width of the delivered-result counter (>=1).

Ports:
- Clock  input  1  rising-edge clock; single clock domain.
- Reset  input  1  synchronous, active-high reset.
- In_Valid  input  1  Input_A/Input_B carry a valid operand pair.
- In_Ready  output  1  block can accept an operand pair this cycle.
- Input_A  input  WIDTH  operand A.
- Input_B  input  WIDTH  operand B.
- Out_Valid  output  1  Output and flags carry a valid result.
- Out_Ready  input  1  downstream accepts the result this cycle.
- Output  output  WIDTH  Input_A & Input_B of the accepted pair.
- Out_Zero  output  1  Output == 0; qualified by Out_Valid.
- Out_AllOnes  output  1  Output is all ones; qualified by Out_Valid.
- Op_Count  output  COUNT_WIDTH  number of results transferred since reset.

Behaviour:
- All state updates on the rising edge of Clock. Reset is sampled synchronously; Reset high overrides all other activity in that cycle.
- Reset values:
  - Out_Valid = 0; Output = 0; Out_Zero = 0; Out_AllOnes = 0; Op_Count = 0.
  - Skid buffer is emptied.
  - In_Ready = 0 while Reset is high, and 1 in the first cycle after Reset falls.
- Input accept: an operand pair is accepted on an edge where In_Valid && In_Ready. AND is computed bitwise at accept time and stored, never recomputed later.
- Latency: a pair accepted at edge N, with the output stage empty or draining, appears at Output with Out_Valid = 1 after edge N; i.e. 1 cycle.
- Output transfer: occurs on an edge where Out_Valid && Out_Ready.
- While Out_Valid && !Out_Ready, Output, Out_Zero and Out_AllOnes hold stable.
- Skid buffer:
  - Output register plus one skid entry.
  - In_Ready is a registered flag equal to "skid entry empty".
  - If a pair is accepted while the output is stalled, the pair goes into the skid entry and In_Ready drops the next cycle.
  - When the output transfers, the skid entry, if full, moves to the output register and In_Ready returns to 1.
- Throughput: one result per cycle with Out_Ready held high. No bubbles and no data loss under any Out_Ready pattern. Strict in-order delivery.
- Simultaneous accept and transfer in the same edge is legal. Occupancy is then unchanged and the new result takes its slot in order.
- Out_Zero and Out_AllOnes are 0 whenever Out_Valid = 0.
- When the output empties (Out_Valid falls), Output retains the last transferred value.
- Op_Count increments by 1 on each output transfer. It wraps from 2^COUNT_WIDTH-1 to 0 with no saturation.
- Reset mid-operation: any in-flight and skid results are discarded, not delivered and not counted. Op_Count clears.
- Input_A/Input_B are ignored when In_Valid = 0 or In_Ready = 0. X on data lines while In_Valid = 0 must not propagate to any output.

Test Plan:
- WIDTH=1 truth table, Out_Ready=1: send (A,B) = (0,0),(1,0),(0,1),(1,1). Required Output 0,0,0,1 one cycle after each accept; Out_Zero 1,1,1,0; Out_AllOnes 0,0,0,1; final Op_Count=4.
- WIDTH=8 vectors: A=0xF0,B=0x3C -> 0x30; A=0xFF,B=0xFF -> 0xFF with Out_AllOnes=1; A=0xAA,B=0x55 -> 0x00 with Out_Zero=1.
- Backpressure: hold Out_Ready=0 and send 3 back-to-back pairs. Required: first two accepted, In_Ready=0 after the second, Output stable. Raise Out_Ready: both delivered in order on consecutive cycles, then the third is accepted. Op_Count increments by exactly 2, then 3.
- Streaming: 16 consecutive random pairs with Out_Ready=1. Required: In_Ready stays 1 and one result per cycle matches A&B in order.
- Reset mid-operation: stall with both entries full, assert Reset for 1 cycle. Required: Out_Valid=0, Output=0, Op_Count=0, In_Ready=0 during reset and 1 the next cycle; no stale result ever emitted.
- Counter wrap with COUNT_WIDTH=3: deliver 9 results. Required Op_Count sequence ends ...7,0,1.
